// File: rtl/sm_mem_req_scheduler.sv
// Round-robin L2 request scheduler with registered, handshake-held grant and per-SM credit limits.
// Optional credit tracking is enabled by defining SMREQ_CREDIT_LIMIT_EN.
module sm_mem_req_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_IDX_W       = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NUM_REQ-1:0]       grant_oh_o,
  output logic [REQ_IDX_W-1:0]     grant_bin_o,
  input  logic                     rsp_fire_i,
  input  logic [REQ_IDX_W-1:0]     rsp_idx_i,
  output logic [NUM_REQ*CNT_W-1:0] outstanding_o,
  output logic                     err_o
);

  // Handshake: a request moves downstream on a cycle where out_valid_o and
  // out_ready_i are both high; req_ready_o mirrors that fire onto the granted SM.
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                r_state, w_state_n;
  logic [NUM_REQ-1:0]    r_grant_oh, w_grant_oh_n;
  logic [REQ_IDX_W-1:0]  r_grant_bin, w_grant_bin_n;
  logic [REQ_IDX_W-1:0]  r_ptr, w_ptr_n, w_next_ptr, w_base;
  logic                  r_err;
  logic                  w_fire, w_found, w_drop_err, w_cnt_err;
  logic [NUM_REQ-1:0]    w_credit_ok, w_elig, w_win_oh;
  logic [REQ_IDX_W-1:0]  w_win_bin;

  assign w_fire     = (r_state == S_HOLD) & out_ready_i;
  assign w_next_ptr = (r_grant_bin == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_bin + 1'b1;
  assign w_base     = w_fire ? w_next_ptr : r_ptr;
  // The firing requester's current valid is consumed, so it cannot re-win this cycle.
  assign w_elig     = req_valid_i & w_credit_ok & ~(r_grant_oh & {NUM_REQ{w_fire}});
  assign w_drop_err = (r_state == S_HOLD) & ~out_ready_i & ~|(req_valid_i & r_grant_oh);

  // Pick the eligible index with the smallest round-robin distance from w_base.
  always_comb begin
    int d;
    w_found   = 1'b0;
    w_win_oh  = '0;
    w_win_bin = '0;
    d         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        d = i - int'(w_base);
        if (d < 0) d = d + NUM_REQ;
        if (!w_found && w_elig[i] && (d == k)) begin
          w_found     = 1'b1;
          w_win_oh[i] = 1'b1;
          w_win_bin   = REQ_IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_grant_oh_n  = r_grant_oh;
    w_grant_bin_n = r_grant_bin;
    w_ptr_n       = w_fire ? w_next_ptr : r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n     = S_HOLD;
          w_grant_oh_n  = w_win_oh;
          w_grant_bin_n = w_win_bin;
        end
      end
      S_HOLD: begin
        if (w_fire) begin
          w_state_n     = w_found ? S_HOLD : S_IDLE;
          w_grant_oh_n  = w_win_oh;
          w_grant_bin_n = w_win_bin;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant_oh  <= '0;
      r_grant_bin <= '0;
      r_ptr       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_grant_oh  <= w_grant_oh_n;
      r_grant_bin <= w_grant_bin_n;
      r_ptr       <= w_ptr_n;
      r_err       <= r_err | w_drop_err | w_cnt_err;
    end
  end

`ifdef SMREQ_CREDIT_LIMIT_EN
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]   r_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] w_rsp_oh, w_cnt_zero, w_cnt_inc, w_cnt_dec;

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_oh[i]    = rsp_fire_i && (rsp_idx_i == REQ_IDX_W'(i));
      w_cnt_zero[i]  = (r_cnt[i] == '0);
      w_credit_ok[i] = (r_cnt[i] < MAX_CNT);
      w_cnt_inc[i]   = w_fire & r_grant_oh[i];
      // A response against an empty counter is an error and must not wrap.
      w_cnt_dec[i]   = w_rsp_oh[i] & ~w_cnt_zero[i];
      outstanding_o[CNT_W*i +: CNT_W] = r_cnt[i];
    end
  end

  assign w_cnt_err = |(w_rsp_oh & w_cnt_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_cnt_inc[i] && !w_cnt_dec[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_cnt_dec[i] && !w_cnt_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end
`else
  logic w_unused_rsp;

  assign w_credit_ok   = '1;
  assign w_cnt_err     = 1'b0;
  assign outstanding_o = '0;
  assign w_unused_rsp  = ^{rsp_fire_i, rsp_idx_i};
`endif

  assign out_valid_o = (r_state == S_HOLD);
  assign req_ready_o = r_grant_oh & {NUM_REQ{out_ready_i}};
  assign grant_oh_o  = r_grant_oh;
  assign grant_bin_o = r_grant_bin;
  assign err_o       = r_err;

endmodule

// File: tb/tb_sm_mem_req_scheduler.sv
// Bench for sm_mem_req_scheduler: vector table for arbitration/hold, hand sequences for
// errors, async reset and (with SMREQ_CREDIT_LIMIT_EN) credit behaviour; fires checked by a scoreboard.
module tb_sm_mem_req_scheduler;

  localparam int NUM_REQ         = 4;
  localparam int REQ_IDX_W       = 2;
  localparam int MAX_OUTSTANDING = 8;
  localparam int CNT_W           = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid_i = '0;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     out_valid_o;
  logic                     out_ready_i = 1'b0;
  logic [NUM_REQ-1:0]       grant_oh_o;
  logic [REQ_IDX_W-1:0]     grant_bin_o;
  logic                     rsp_fire_i = 1'b0;
  logic [REQ_IDX_W-1:0]     rsp_idx_i = '0;
  logic [NUM_REQ*CNT_W-1:0] outstanding_o;
  logic                     err_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [REQ_IDX_W-1:0] exp_q[$];

  typedef struct {
    logic [NUM_REQ-1:0]   valid;
    logic                 rdy;
    logic                 exp_ov;
    logic [REQ_IDX_W-1:0] exp_g;
    logic [NUM_REQ-1:0]   exp_rr;
  } vec_t;

  vec_t vecs [16];

  // Clock and reset
  always #5 clk = ~clk;

  sm_mem_req_scheduler #(
    .NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .grant_oh_o(grant_oh_o), .grant_bin_o(grant_bin_o),
    .rsp_fire_i(rsp_fire_i), .rsp_idx_i(rsp_idx_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int i);
    return outstanding_o[CNT_W*i +: CNT_W];
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid_i = '0;
    out_ready_i = 1'b0;
    rsp_fire_i  = 1'b0;
    rsp_idx_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ov"},  out_valid_o, 0);
    check({tag, "_goh"}, grant_oh_o, 0);
    check({tag, "_gb"},  grant_bin_o, 0);
    check({tag, "_rr"},  req_ready_o, 0);
    check({tag, "_out"}, outstanding_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  // Scoreboard: every downstream fire must match the next expected grant.
  always @(negedge clk) begin : mon
    logic [REQ_IDX_W-1:0] e;
    logic [NUM_REQ-1:0]   oh;
    if (rst === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: grant %0d fired, expected no fire (t=%0t)", grant_bin_o, $time);
      end else begin
        e = exp_q.pop_front();
        oh = '0;
        oh[e] = 1'b1;
        check("sb_grant_bin", grant_bin_o, e);
        check("sb_grant_oh", grant_oh_o, oh);
        check("sb_req_ready", req_ready_o, oh);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // valid, ready, exp out_valid, exp grant_bin, exp req_ready
    vecs[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[6]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010};
    vecs[7]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[8]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[9]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    vecs[10] = '{4'b1101, 1'b0, 1'b1, 2'd2, 4'b0000};
    vecs[11] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    vecs[12] = '{4'b0110, 1'b0, 1'b1, 2'd2, 4'b0000};
    vecs[13] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    vecs[14] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
    vecs[15] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};

    do_reset();
    check_idle("reset");

    // Round-robin sweep, then a held grant with stalled downstream
    for (int v = 0; v < 16; v++) begin
      req_valid_i = vecs[v].valid;
      out_ready_i = vecs[v].rdy;
      #2;
      check($sformatf("vec%0d_ov", v), out_valid_o, vecs[v].exp_ov);
      check($sformatf("vec%0d_gb", v), grant_bin_o, vecs[v].exp_g);
      check($sformatf("vec%0d_rr", v), req_ready_o, vecs[v].exp_rr);
      if (vecs[v].exp_ov && vecs[v].rdy) exp_q.push_back(vecs[v].exp_g);
      step();
    end
    check("table_err", err_o, 0);

    // Dropped valid while held without a fire
    do_reset();
    req_valid_i = 4'b0001;
    out_ready_i = 1'b0;
    step();
    check("drop_hold_ov", out_valid_o, 1);
    check("drop_pre_err", err_o, 0);
    req_valid_i = 4'b0000;
    step();
    check("drop_err_set", err_o, 1);
    exp_q.push_back(2'd0);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("drop_err_sticky", err_o, 1);
    check("drop_idle_ov", out_valid_o, 0);
    do_reset();
    check("drop_err_cleared", err_o, 0);

    // Asynchronous reset while holding a grant
    req_valid_i = 4'b0011;
    out_ready_i = 1'b1;
    exp_q.push_back(2'd0);
    step();
    step();
    out_ready_i = 1'b0;
    check("arst_pre_ov", out_valid_o, 1);
    check("arst_pre_gb", grant_bin_o, 1);
`ifdef SMREQ_CREDIT_LIMIT_EN
    check("arst_pre_cnt0", cnt_of(0), 1);
`endif
    out_ready_i = 1'b1;
    #1;
    check("arst_pre_rr", req_ready_o, 4'b0010);
    rst = 1'b1;
    #1;
    check_idle("arst");
    req_valid_i = '0;
    out_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef SMREQ_CREDIT_LIMIT_EN
    // Lone requester runs to its credit limit, then one response frees one credit
    do_reset();
    req_valid_i = 4'b0010;
    out_ready_i = 1'b1;
    for (int i = 0; i < MAX_OUTSTANDING; i++) exp_q.push_back(2'd1);
    repeat (30) step();
    check("limit_ov", out_valid_o, 0);
    check("limit_cnt1", cnt_of(1), MAX_OUTSTANDING);
    check("limit_sb_empty", exp_q.size(), 0);
    rsp_fire_i = 1'b1;
    rsp_idx_i  = 2'd1;
    exp_q.push_back(2'd1);
    step();
    rsp_fire_i = 1'b0;
    check("credit_freed_cnt", cnt_of(1), MAX_OUTSTANDING - 1);
    check("credit_freed_ov", out_valid_o, 0);
    step();
    check("credit_reuse_ov", out_valid_o, 1);
    check("credit_reuse_gb", grant_bin_o, 1);
    repeat (6) step();
    check("credit_refill_cnt", cnt_of(1), MAX_OUTSTANDING);
    check("credit_refill_sb", exp_q.size(), 0);

    // Fire and response on the same SM in one cycle
    do_reset();
    req_valid_i = 4'b1000;
    out_ready_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      out_ready_i = 1'b1;
      exp_q.push_back(2'd3);
      step();
      out_ready_i = 1'b0;
      step();
    end
    check("same_pre_cnt3", cnt_of(3), 5);
    out_ready_i = 1'b1;
    rsp_fire_i  = 1'b1;
    rsp_idx_i   = 2'd3;
    exp_q.push_back(2'd3);
    step();
    rsp_fire_i  = 1'b0;
    out_ready_i = 1'b0;
    req_valid_i = '0;
    check("same_cnt3", cnt_of(3), 5);
    check("same_err", err_o, 0);

    // Response against an empty counter
    do_reset();
    rsp_fire_i = 1'b1;
    rsp_idx_i  = 2'd0;
    step();
    rsp_fire_i = 1'b0;
    check("uflow_err", err_o, 1);
    check("uflow_cnt0", cnt_of(0), 0);
    step();
    check("uflow_sticky", err_o, 1);
`else
    // Responses are ignored when credits are compiled out
    do_reset();
    rsp_fire_i = 1'b1;
    rsp_idx_i  = 2'd0;
    step();
    rsp_fire_i = 1'b0;
    check("rsp_ignored_err", err_o, 0);
    check("rsp_ignored_out", outstanding_o, 0);
    check("rsp_ignored_ov", out_valid_o, 0);
`endif

    step();
    check("sb_drained", exp_q.size(), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
